bk_sub_pipe: RTL and testbench

Pipelined 12-bit Brent-Kung subtractor that inverts the team's 12-bit Brent-Kung adder: given a 13-bit sum and one 12-bit addend, it recovers the other 12-bit operand (DIFF = SUM − ADDEND). It sits on the check-back path after the adder, reconstructing operands for equivalence checks and DRiLLS regression scoring. It uses a two-stage pipeline with valid/ready handshakes on both sides, and sustains one result per cycle.

---
 rtl/bk_sub_pipe.sv | 230 +++++++++++++++++++++++
 tb/tb_bk_sub_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bk_sub_pipe.sv
// bk_sub_pipe - two-stage pipelined 12-bit Brent-Kung subtractor.
//
// Recovers the unknown operand of the team's 12-bit Brent-Kung adder from
// its 13-bit sum and the known addend: DIFF = SUM - ADDEND (low 12 bits).
// The subtraction is SUM + ~{1'b0,ADDEND} + 1 at 13 bits, with the carry-in
// folded into bit 0 of the prefix tree.
//
// Stage 1 registers the per-bit propagate vector and the up-sweep groups
// (spans 2, 4, 8). Stage 2 finishes the down-sweep, forms DIFF and
// registers it as the output.
//
// Optional feature: define BK_SUB_RANGE_CHECK_EN to add the ERR output
// (borrow, or a difference larger than 4095). Without it the ERR port, the
// bit-12 / carry-out logic and the extra stage registers do not exist.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   SUM/ADDEND valid
//   in_ready   out  block accepts an input this cycle
//   SUM        in   13-bit minuend (adder OUTS[12:0])
//   ADDEND     in   12-bit subtrahend
//   out_valid  out  DIFF/ERR valid
//   out_ready  in   downstream accepts the output this cycle
//   DIFF       out  low 12 bits of SUM - ADDEND
//   ERR        out  result out of range (BK_SUB_RANGE_CHECK_EN only)
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high; valid never depends on ready, and once out_valid is high it
// stays high with DIFF/ERR constant until out_ready accepts it.
// in_ready depends on out_ready and pipeline state only, never on in_valid.

module bk_sub_pipe #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   SUM,
  input  logic [WIDTH-1:0] ADDEND,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] DIFF
`ifdef BK_SUB_RANGE_CHECK_EN
  ,
  output logic             ERR
`endif
);

  // PW: bits of the propagate vector kept; GW: bits of the prefix tree kept.
  // DIFF alone needs carries into bits 0..11, i.e. prefixes 0..10.
`ifdef BK_SUB_RANGE_CHECK_EN
  localparam int PW = 13;
  localparam int GW = 13;
`else
  localparam int PW = 12;
  localparam int GW = 11;
`endif

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_load;
  logic in_fire;

  // S2 can take new data when empty or when its result leaves this cycle.
  assign s2_load   = ~s2_valid_q | out_ready;
  assign in_ready  = rst_n & (~s1_valid_q | s2_load);
  assign in_fire   = in_valid & in_ready;
  assign out_valid = s2_valid_q;

  assign s1_valid_d = in_fire | (s1_valid_q & ~s2_load);
  assign s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;

  // ---------------------------------------------------------------------
  // Stage 1: generate/propagate and Brent-Kung up-sweep
  // ---------------------------------------------------------------------
  logic [PW-1:0] s_in;
  logic [PW-1:0] a_n;
  logic [PW-1:0] p_raw;
  logic [GW-1:0] g_raw;

`ifdef BK_SUB_RANGE_CHECK_EN
  assign s_in = SUM;
  assign a_n  = ~{1'b0, ADDEND};
`else
  // SUM[12] cannot influence the low 12 bits of the difference.
  logic unused_sum_msb;
  assign unused_sum_msb = SUM[12];
  assign s_in = SUM[11:0];
  assign a_n  = ~ADDEND;
`endif

  assign p_raw = s_in ^ a_n;
  assign g_raw = s_in[GW-1:0] & a_n[GW-1:0];

  logic g0m, g1f;
  logic g32, p32, g54, p54, g76, p76, g98, p98;
  logic g3f, g74, p74, g7f;
  logic [GW-1:0] gx_d;
`ifdef BK_SUB_RANGE_CHECK_EN
  logic g1110, p1110, g118, p118;
`endif

  always_comb begin
    // Carry-in of 1 folded into bit 0: G[0:-1] = g0 | p0.
    g0m = g_raw[0] | p_raw[0];
    // Span 2.
    g1f = g_raw[1] | (p_raw[1] & g0m);
    g32 = g_raw[3] | (p_raw[3] & g_raw[2]);
    p32 = p_raw[3] & p_raw[2];
    g54 = g_raw[5] | (p_raw[5] & g_raw[4]);
    p54 = p_raw[5] & p_raw[4];
    g76 = g_raw[7] | (p_raw[7] & g_raw[6]);
    p76 = p_raw[7] & p_raw[6];
    g98 = g_raw[9] | (p_raw[9] & g_raw[8]);
    p98 = p_raw[9] & p_raw[8];
    // Span 4.
    g3f = g32 | (p32 & g1f);
    g74 = g76 | (p76 & g54);
    p74 = p76 & p54;
    // Span 8.
    g7f = g74 | (p74 & g3f);

    // In-place tree: odd positions hold group G, even positions raw g.
    gx_d    = g_raw;
    gx_d[0] = g0m;
    gx_d[1] = g1f;
    gx_d[3] = g3f;
    gx_d[5] = g54;
    gx_d[7] = g7f;
    gx_d[9] = g98;
`ifdef BK_SUB_RANGE_CHECK_EN
    g1110    = g_raw[11] | (p_raw[11] & g_raw[10]);
    p1110    = p_raw[11] & p_raw[10];
    g118     = g1110 | (p1110 & g98);
    p118     = p1110 & p98;
    gx_d[11] = g118;
`endif
  end

  logic [PW-1:0] p1_q;
  logic [GW-1:0] gx1_q;
  logic          pg5_q, pg9_q;
`ifdef BK_SUB_RANGE_CHECK_EN
  logic          pg11_q;
`endif

  // ---------------------------------------------------------------------
  // Stage 2: Brent-Kung down-sweep and difference bits
  // ---------------------------------------------------------------------
  logic [GW-1:0]    pref;   // pref[i] = carry out of bit i
  logic [PW-1:0]    c_vec;  // carry into each bit
  logic [PW-1:0]    d_full;
  logic [WIDTH-1:0] diff_d;

  always_comb begin
    pref[0]  = gx1_q[0];
    pref[1]  = gx1_q[1];
    pref[3]  = gx1_q[3];
    pref[7]  = gx1_q[7];
    // Span 2 down-sweep from completed prefixes 3 and 7.
    pref[5]  = gx1_q[5] | (pg5_q & pref[3]);
    pref[9]  = gx1_q[9] | (pg9_q & pref[7]);
    // Span 1: each even bit joins the completed prefix below it.
    pref[2]  = gx1_q[2]  | (p1_q[2]  & pref[1]);
    pref[4]  = gx1_q[4]  | (p1_q[4]  & pref[3]);
    pref[6]  = gx1_q[6]  | (p1_q[6]  & pref[5]);
    pref[8]  = gx1_q[8]  | (p1_q[8]  & pref[7]);
    pref[10] = gx1_q[10] | (p1_q[10] & pref[9]);
`ifdef BK_SUB_RANGE_CHECK_EN
    // Span 4 down-sweep, then bit 12 for the carry-out.
    pref[11] = gx1_q[11] | (pg11_q & pref[7]);
    pref[12] = gx1_q[12] | (p1_q[12] & pref[11]);
`endif
    c_vec  = {pref[PW-2:0], 1'b1};
    d_full = p1_q ^ c_vec;
    diff_d = d_full[WIDTH-1:0];
  end

  logic [WIDTH-1:0] diff_q;
  assign DIFF = diff_q;

`ifdef BK_SUB_RANGE_CHECK_EN
  logic err_q, err_d;
  // No carry-out means a borrow; bit 12 set means the result exceeds 4095.
  assign err_d = ~pref[12] | d_full[12];
  assign ERR   = err_q;
`endif

  // ---------------------------------------------------------------------
  // Registers. Data registers only change on a load, so a stalled S2
  // holds DIFF/ERR. Only valids and the outputs need a reset value.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
`ifdef BK_SUB_RANGE_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s2_load && s1_valid_q) begin
        diff_q <= diff_d;
`ifdef BK_SUB_RANGE_CHECK_EN
        err_q  <= err_d;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      p1_q   <= p_raw;
      gx1_q  <= gx_d;
      pg5_q  <= p54;
      pg9_q  <= p98;
`ifdef BK_SUB_RANGE_CHECK_EN
      pg11_q <= p118;
`endif
    end
  end

endmodule

// File: tb/tb_bk_sub_pipe.sv
// tb_bk_sub_pipe - directed and random checks for bk_sub_pipe.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Define BK_SUB_RANGE_CHECK_EN to also check ERR.

module tb_bk_sub_pipe;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] sum;
  logic [11:0] addend;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] diff;
`ifdef BK_SUB_RANGE_CHECK_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  bk_sub_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SUM       (sum),
    .ADDEND    (addend),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .DIFF      (diff)
`ifdef BK_SUB_RANGE_CHECK_EN
    ,
    .ERR       (err)
`endif
  );

  // ---------------- scoreboard state ----------------
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          pops         = 0;
  logic [12:0] exp_q[$];
  logic        hold_pending = 1'b0;
  logic [12:0] held_out;

  // Reference: plain integer subtraction, {err, diff}.
  function automatic logic [12:0] model(input logic [12:0] s, input logic [11:0] a);
    logic [13:0] t;
    t = {1'b0, s} - {2'b00, a};
    return {t[13] | t[12], t[11:0]};
  endfunction

  function automatic logic [12:0] mask(input logic [12:0] e);
`ifdef BK_SUB_RANGE_CHECK_EN
    return e;
`else
    return {1'b0, e[11:0]};
`endif
  endfunction

  function automatic logic [12:0] cur_out();
`ifdef BK_SUB_RANGE_CHECK_EN
    return {err, diff};
`else
    return {1'b0, diff};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: drive inputs, then score the transfers the next edge performs.
  task automatic drive(input logic iv, input logic [12:0] s, input logic [11:0] a,
                       input logic ordy, input logic use_hand, input logic [12:0] hand);
    logic [12:0] e;
    @(negedge clk);
    in_valid  = iv;
    sum       = s;
    addend    = a;
    out_ready = ordy;
    #1;
    if (hold_pending) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", {19'd0, cur_out()}, {19'd0, held_out});
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("scoreboard", {19'd0, cur_out()}, {19'd0, mask(e)});
      end
      pops++;
    end
    if (in_valid && in_ready) exp_q.push_back(use_hand ? hand : model(s, a));
    hold_pending = out_valid && !out_ready;
    held_out     = cur_out();
  endtask

  // Directed vectors with hand-computed {err, diff}.
  localparam int NDIR = 9;
  logic [12:0] dir_s   [NDIR] = '{13'h1FFE, 13'h0005, 13'h1000, 13'h0ABC, 13'h1FFF,
                                  13'h0000, 13'h0FFF, 13'h0800, 13'h0000};
  logic [11:0] dir_a   [NDIR] = '{12'hFFF, 12'h006, 12'h000, 12'h123, 12'h000,
                                  12'h000, 12'hFFF, 12'h001, 12'h001};
  logic [12:0] dir_exp [NDIR] = '{13'h0FFF, 13'h1FFF, 13'h1000, 13'h0999, 13'h1FFF,
                                  13'h0000, 13'h0000, 13'h07FF, 13'h1FFF};

  int pops_before;

  initial begin
    // ---------------- reset ----------------
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum       = '0;
    addend    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_diff", {20'd0, diff}, 32'd0);
`ifdef BK_SUB_RANGE_CHECK_EN
    check("reset_err", {31'd0, err}, 32'd0);
`endif
    rst_n = 1'b1;

    // ---------------- single transfer, latency 2 ----------------
    drive(1'b1, 13'h1FFE, 12'hFFF, 1'b1, 1'b1, 13'h0FFF);
    check("lat_in_ready", {31'd0, in_ready}, 32'd1);
    check("lat_c0_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 13'h0, 12'h0, 1'b1, 1'b0, 13'h0);
    check("lat_c1_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 13'h0, 12'h0, 1'b1, 1'b0, 13'h0);
    check("lat_c2_valid", {31'd0, out_valid}, 32'd1);
    check("lat_diff", {20'd0, diff}, 32'h0FFF);
`ifdef BK_SUB_RANGE_CHECK_EN
    check("lat_err", {31'd0, err}, 32'd0);
`endif
    drive(1'b0, 13'h0, 12'h0, 1'b1, 1'b0, 13'h0);
    check("empty_after_last", {31'd0, out_valid}, 32'd0);

    // ---------------- directed vectors incl. range errors ----------------
    for (int i = 0; i < NDIR; i++)
      drive(1'b1, dir_s[i], dir_a[i], 1'b1, 1'b1, dir_exp[i]);
    repeat (3) drive(1'b0, 13'h0, 12'h0, 1'b1, 1'b0, 13'h0);
    check("dir_drained", exp_q.size(), 32'd0);

    // ---------------- streaming, 4096 back-to-back ----------------
    for (int i = 0; i < 4096; i++) begin
      drive(1'b1, 13'($urandom_range(0, 8191)), 12'($urandom_range(0, 4095)),
            1'b1, 1'b0, 13'h0);
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      if (i >= 2) check("stream_out_valid", {31'd0, out_valid}, 32'd1);
    end
    repeat (3) drive(1'b0, 13'h0, 12'h0, 1'b1, 1'b0, 13'h0);
    check("stream_drained", exp_q.size(), 32'd0);

    // ---------------- backpressure ----------------
    drive(1'b1, 13'h0123, 12'h023, 1'b0, 1'b0, 13'h0);
    check("bp_accept0", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 13'h0800, 12'h001, 1'b0, 1'b0, 13'h0);
    check("bp_accept1", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 13'h1FFF, 12'h0FF, 1'b0, 1'b0, 13'h0);
      check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_stall_diff", {20'd0, diff}, 32'h0100);
    end
    pops_before = pops;
    drive(1'b1, 13'h1FFF, 12'h0FF, 1'b1, 1'b0, 13'h0);
    check("bp_drain_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) drive(1'b0, 13'h0, 12'h0, 1'b1, 1'b0, 13'h0);
    check("bp_three_out", pops - pops_before, 32'd3);
    check("bp_drained", exp_q.size(), 32'd0);

    // ---------------- random stall mix ----------------
    for (int i = 0; i < 10000; i++)
      drive(1'($urandom_range(0, 1)), 13'($urandom_range(0, 8191)),
            12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 1'b0, 13'h0);
    repeat (4) drive(1'b0, 13'h0, 12'h0, 1'b1, 1'b0, 13'h0);
    check("mix_drained", exp_q.size(), 32'd0);

    // ---------------- mid-stream reset ----------------
    drive(1'b1, 13'h0ABC, 12'h001, 1'b0, 1'b0, 13'h0);
    drive(1'b1, 13'h0123, 12'h002, 1'b0, 1'b0, 13'h0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_diff", {20'd0, diff}, 32'd0);
`ifdef BK_SUB_RANGE_CHECK_EN
    check("mid_rst_err", {31'd0, err}, 32'd0);
`endif
    check("mid_rst_in_ready_after", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    hold_pending = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 13'h0, 12'h0, 1'b1, 1'b0, 13'h0);
      check("flushed_not_emitted", {31'd0, out_valid}, 32'd0);
    end
    drive(1'b1, 13'h0005, 12'h003, 1'b1, 1'b1, 13'h0002);
    repeat (3) drive(1'b0, 13'h0, 12'h0, 1'b1, 1'b0, 13'h0);
    check("final_drained", exp_q.size(), 32'd0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
